// File: rtl/proc_pkg.sv
// Shared processor definitions: interrupt controller state encoding
// and the default ISR vector map used by the control unit.
package proc_pkg;

    typedef enum logic [1:0] {
        IC_IDLE    = 2'd0,
        IC_REQ     = 2'd1,
        IC_SERVICE = 2'd2
    } ic_state_e;

    localparam int          N_SRC_DEF      = 8;
    localparam int          ADDR_W_DEF     = 10;
    localparam logic [9:0]  ISR_BASE_DEF   = 10'h3C0;
    localparam int          ISR_STRIDE_DEF = 8;

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: reports the index of the lowest set bit
// of req, plus a valid flag when any bit is set.
module prio_enc #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] id,
    output logic         valid
);

    // Scan from the top so the lowest set index is the last written.
    always_comb begin
        id    = '0;
        valid = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = W'(i);
            end
        end
    end

endmodule

// File: rtl/int_controller.sv
// Vectored interrupt controller: edge-detected pending bits, mask,
// fixed priority and an irq/ack/iret handshake with the CPU.
module int_controller
    import proc_pkg::*;
#(
    parameter int              N_SRC      = N_SRC_DEF,
    parameter int              ID_W       = 3,
    parameter int              ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] ISR_BASE = ISR_BASE_DEF,
    parameter int              ISR_STRIDE = ISR_STRIDE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  src,
    input  logic              mask_we,
    input  logic [N_SRC-1:0]  mask_in,
    input  logic              ack,
    input  logic              iret,
    output logic              irq,
    output logic [ID_W-1:0]   irq_id,
    output logic [ADDR_W-1:0] irq_addr,
    output logic              in_service,
    output logic [N_SRC-1:0]  pending
);

    ic_state_e         state_q, state_d;
    logic [N_SRC-1:0]  src_q_q, src_q_d;
    logic [N_SRC-1:0]  pending_q, pending_d;
    logic [N_SRC-1:0]  mask_q, mask_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [N_SRC-1:0]  rise;
    logic [N_SRC-1:0]  req;
    logic [N_SRC-1:0]  clr;
    logic [ID_W-1:0]   prio_id;
    logic              prio_vld;

    assign rise = src & ~src_q_q;
    assign req  = pending_q & mask_q;

    prio_enc #(
        .N (N_SRC),
        .W (ID_W)
    ) u_prio (
        .req   (req),
        .id    (prio_id),
        .valid (prio_vld)
    );

    // Next state, latched vector and pending/mask updates.
    // A fresh edge on the bit being acknowledged beats its clear.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        clr     = '0;
        case (state_q)
            IC_IDLE: begin
                if (prio_vld) begin
                    state_d = IC_REQ;
                    id_d    = prio_id;
                    addr_d  = ISR_BASE
                            + ADDR_W'(prio_id) * ADDR_W'(ISR_STRIDE);
                end
            end
            IC_REQ: begin
                if (ack) begin
                    state_d     = IC_SERVICE;
                    clr[id_q]   = 1'b1;
                end else if (!req[id_q]) begin
                    state_d = IC_IDLE;
                end
            end
            IC_SERVICE: begin
                if (iret) begin
                    state_d = IC_IDLE;
                end
            end
            default: state_d = IC_IDLE;
        endcase
        src_q_d   = src;
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = mask_we ? mask_in : mask_q;
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IC_IDLE;
            src_q_q   <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            id_q      <= '0;
            addr_q    <= ISR_BASE;
        end else begin
            state_q   <= state_d;
            src_q_q   <= src_q_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
        end
    end

    assign irq        = (state_q == IC_REQ);
    assign in_service = (state_q == IC_SERVICE);
    assign irq_id     = id_q;
    assign irq_addr   = addr_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed scenarios and random traffic,
// every cycle compared against a behavioural reference model.
module tb_int_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] src;
    logic       mask_we;
    logic [7:0] mask_in;
    logic       ack;
    logic       iret;
    logic       irq;
    logic [2:0] irq_id;
    logic [9:0] irq_addr;
    logic       in_service;
    logic [7:0] pending;

    int n_vec = 0;
    int n_err = 0;

    // reference model: 0 = idle, 1 = requesting, 2 = in service
    int         m_mode;
    int         m_id;
    logic [7:0] m_prev;
    logic [7:0] m_pend;
    logic [7:0] m_mask;

    always #5 clk = ~clk;

    int_controller dut (
        .clk        (clk),
        .reset      (reset),
        .src        (src),
        .mask_we    (mask_we),
        .mask_in    (mask_in),
        .ack        (ack),
        .iret       (iret),
        .irq        (irq),
        .irq_id     (irq_id),
        .irq_addr   (irq_addr),
        .in_service (in_service),
        .pending    (pending)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // One clock of the controller rules, from current tb inputs.
    task automatic model_step();
        logic [7:0] enabled;
        logic [7:0] rising;
        if (reset) begin
            m_mode = 0;
            m_id   = 0;
            m_prev = 8'h00;
            m_pend = 8'h00;
            m_mask = 8'h00;
            return;
        end
        enabled = m_pend & m_mask;
        rising  = src & ~m_prev;
        if (m_mode == 0) begin
            if (enabled != 0) begin
                m_mode = 1;
                m_id   = lowest(enabled);
            end
        end else if (m_mode == 1) begin
            if (ack) begin
                m_pend[m_id] = 1'b0;
                m_mode       = 2;
            end else if (!enabled[m_id]) begin
                m_mode = 0;
            end
        end else begin
            if (iret) m_mode = 0;
        end
        m_pend = m_pend | rising;
        if (mask_we) m_mask = mask_in;
        m_prev = src;
    endtask

    task automatic cmp_all();
        int a;
        a = ('h3C0 + m_id * 8) % 1024;
        chk("irq", 32'(irq), 32'(m_mode == 1));
        chk("in_service", 32'(in_service), 32'(m_mode == 2));
        chk("irq_id", 32'(irq_id), 32'(m_id));
        chk("irq_addr", 32'(irq_addr), 32'(a));
        chk("pending", 32'(pending), 32'(m_pend));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cmp_all();
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic do_iret();
        iret = 1'b1;
        tick();
        iret = 1'b0;
    endtask

    task automatic set_mask(input logic [7:0] m);
        mask_we = 1'b1;
        mask_in = m;
        tick();
        mask_we = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        src     = 8'h00;
        mask_we = 1'b0;
        mask_in = 8'h00;
        ack     = 1'b0;
        iret    = 1'b0;
        m_mode  = 0;
        m_id    = 0;
        m_prev  = 8'h00;
        m_pend  = 8'h00;
        m_mask  = 8'h00;
        tick();
        tick();
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_addr", 32'(irq_addr), 32'h3C0);
        reset = 1'b0;

        // single pulse on source 3
        set_mask(8'hFF);
        src = 8'h08;
        tick();
        src = 8'h00;
        chk("t1_early", 32'(irq), 32'd0);
        tick();
        chk("t1_irq", 32'(irq), 32'd1);
        chk("t1_id", 32'(irq_id), 32'd3);
        chk("t1_addr", 32'(irq_addr), 32'h3D8);
        do_ack();
        chk("t1_svc", 32'(in_service), 32'd1);
        chk("t1_pend", 32'(pending), 32'h00);
        do_iret();
        chk("t1_idle", 32'(in_service), 32'd0);

        // two simultaneous edges, lowest index first
        src = 8'h24;
        tick();
        src = 8'h00;
        tick();
        chk("t2_id", 32'(irq_id), 32'd2);
        do_ack();
        do_iret();
        tick();
        chk("t2_irq5", 32'(irq), 32'd1);
        chk("t2_id5", 32'(irq_id), 32'd5);
        do_ack();
        do_iret();

        // masked source collects pending, released by mask write
        set_mask(8'h00);
        src = 8'h02;
        tick();
        src = 8'h00;
        tick();
        tick();
        chk("t3_noirq", 32'(irq), 32'd0);
        chk("t3_pend", 32'(pending), 32'h02);
        set_mask(8'h02);
        tick();
        chk("t3_irq", 32'(irq), 32'd1);
        chk("t3_id", 32'(irq_id), 32'd1);
        do_ack();
        do_iret();

        // mask cleared while requesting withdraws the request
        set_mask(8'hFF);
        src = 8'h10;
        tick();
        src = 8'h00;
        tick();
        chk("t4_req", 32'(irq_id), 32'd4);
        set_mask(8'hEF);
        tick();
        chk("t4_drop", 32'(irq), 32'd0);
        chk("t4_pend", 32'(pending[4]), 32'd1);
        set_mask(8'hFF);
        tick();
        do_ack();
        do_iret();

        // edges during service and in the ack cycle
        src = 8'h01;
        tick();
        src = 8'h00;
        tick();
        do_ack();
        src = 8'h01;
        tick();
        src = 8'h00;
        chk("t5_pend", 32'(pending[0]), 32'd1);
        chk("t5_noirq", 32'(irq), 32'd0);
        do_iret();
        tick();
        chk("t5_rereq", 32'(irq), 32'd1);
        src = 8'h01;
        do_ack();
        src = 8'h00;
        chk("t5_ackedge", 32'(pending[0]), 32'd1);
        do_iret();
        tick();
        do_ack();
        do_iret();

        // reset mid-request, mid-service and with a held source
        src = 8'h40;
        tick();
        src = 8'h00;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rreq", 32'(irq), 32'd0);
        chk("t6_rpend", 32'(pending), 32'h00);
        set_mask(8'hFF);
        src = 8'h80;
        tick();
        src = 8'h00;
        tick();
        do_ack();
        reset = 1'b1;
        tick();
        chk("t6_rsvc", 32'(in_service), 32'd0);
        chk("t6_rid", 32'(irq_id), 32'd0);
        src = 8'h02;
        tick();
        reset = 1'b0;
        tick();
        chk("t6_held", 32'(pending), 32'h02);
        set_mask(8'hFF);
        tick();
        do_ack();
        tick();
        chk("t6_once", 32'(pending), 32'h00);
        do_iret();
        src = 8'h00;
        tick();

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 2) == 0)
                src = src ^ (8'($urandom) & 8'($urandom));
            mask_we = ($urandom_range(0, 9) == 0);
            mask_in = 8'($urandom) | 8'($urandom);
            ack     = ($urandom_range(0, 2) == 0);
            iret    = ($urandom_range(0, 3) == 0);
            reset   = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
